pc_stack_seq: RTL

Program-counter sequencer for the FPGA RISC CPU with a parametrised address width and a multi-level return-address stack. Each enabled clock edge decodes the instruction register and advances, jumps, conditionally branches, calls or returns. It replaces the single-level return register with a `DEPTH`-entry stack and adds an external vector load, overflow/underflow flags and an explicit branch-wait indication. The PC output drives program-memory addressing; `ir` and `ccr` come from the instruction register and condition-code register.

---
 rtl/pc_stack_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_stack_seq.sv
// pc_stack_seq: program-counter sequencer for the RISC CPU.
// Jump, conditional branch, relative call and return over a DEPTH-entry stack.
module pc_stack_seq #(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [15:0]    ir,
  input  logic [3:0]     ccr,
  input  logic           ld,
  input  logic [AW-1:0]  ld_addr,
  output logic [AW-1:0]  pc,
  output logic           wait_cond,
  output logic [SPW-1:0] sp,
  output logic           stk_ovf,
  output logic           stk_unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_PRIME = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [1:0]     state_q;
  logic [1:0]     state_d;
  logic [AW-1:0]  pc_d;
  logic [AW-1:0]  pc_inc;
  logic [SPW-1:0] sp_d;
  logic           ovf_d;
  logic           unf_d;
  logic           push;
  logic           cond;

  logic [AW-1:0]  stk [DEPTH];

  logic [3:0]     op;
  logic [AW-1:0]  tgt;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic           is_ret;
  logic           is_jmp;
  logic           is_jcc;
  logic           is_bsr;
  logic           unused_ok;

  assign op     = ir[15:12];
  assign tgt    = ir[AW-1:0];
  assign pc_inc = pc + AW'(1);
  assign wr_idx = sp[IW-1:0];
  assign rd_idx = IW'(sp - SPW'(1));

  assign is_ret = (op == 4'h0) && (ir[11:8] == 4'hD);
  assign is_jmp = (op == 4'h8);
  assign is_jcc = (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
  assign is_bsr = (op == 4'hE);

  assign unused_ok = ^{ccr[1], ir};

  // Select the condition bit tested by a pending branch.
  always_comb begin
    cond = 1'b0;
    case (op)
      4'h9:    cond = ccr[2];
      4'hA:    cond = ccr[3];
      4'hB:    cond = ccr[0];
      default: cond = 1'b0;
    endcase
  end

  // Next PC, state, stack pointer and flags for one enabled edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    sp_d    = sp;
    ovf_d   = stk_ovf;
    unf_d   = stk_unf;
    push    = 1'b0;
    if (ld) begin
      pc_d    = ld_addr;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_PRIME: state_d = S_RUN;
        S_WAIT: begin
          state_d = S_RUN;
          pc_d    = (is_jcc && cond) ? tgt : pc_inc;
        end
        S_RUN: begin
          unique case (1'b1)
            is_ret: begin
              if (sp != '0) begin
                pc_d = stk[rd_idx] + AW'(1);
                sp_d = sp - SPW'(1);
              end else begin
                unf_d = 1'b1;
                pc_d  = pc_inc;
              end
            end
            is_jmp: pc_d = tgt;
            is_jcc: state_d = S_WAIT;
            is_bsr: begin
              if (sp != SP_FULL) begin
                push = 1'b1;
                sp_d = sp + SPW'(1);
              end else begin
                ovf_d = 1'b1;
              end
              pc_d = pc + tgt;
            end
            default: pc_d = pc_inc;
          endcase
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Sequencer registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PRIME;
      pc        <= '0;
      sp        <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      wait_cond <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      pc        <= pc_d;
      sp        <= sp_d;
      stk_ovf   <= ovf_d;
      stk_unf   <= unf_d;
      wait_cond <= (state_d == S_WAIT);
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (en && push) begin
      stk[wr_idx] <= pc;
    end
  end

endmodule
